// File: rtl/fwrisc_rf_arbiter.sv
// rtl/fwrisc_rf_arbiter.sv - two-requester GPR read-port arbiter with starvation guard
// Decode (r0) wins by default; CSR/debug (r1) is forced through after STARVE_LIMIT denied cycles.
module fwrisc_rf_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        r0_req,
  input  logic [5:0]  r0_ra_addr,
  input  logic [5:0]  r0_rb_addr,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_ra_data,
  output logic [31:0] r0_rb_data,
  input  logic        r1_req,
  input  logic [5:0]  r1_addr,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic [5:0]  ra_raddr,
  input  logic [31:0] ra_rdata,
  output logic [5:0]  rb_raddr,
  input  logic [31:0] rb_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_R0,
    OWN_R1
  } owner_e;

  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic [5:0] ra_q, rb_q;

  always_comb begin
    r0_gnt   = 1'b0;
    r1_gnt   = 1'b0;
    starve_d = starve_q;
    owner_d  = OWN_NONE;
    ra_raddr = ra_q;
    rb_raddr = rb_q;
    if (reset) begin
      ra_raddr = '0;
      rb_raddr = '0;
      starve_d = '0;
    end else begin
      if (r1_req && (!r0_req || starve_q == LIMIT)) begin
        r1_gnt = 1'b1;
      end else if (r0_req) begin
        r0_gnt = 1'b1;
      end

      if (r1_gnt) begin
        starve_d = '0;
        owner_d  = OWN_R1;
        ra_raddr = r1_addr;
        rb_raddr = '0;
      end else begin
        if (r1_req && starve_q < LIMIT) begin
          starve_d = starve_q + 4'd1;
        end
        if (r0_gnt) begin
          owner_d  = OWN_R0;
          ra_raddr = r0_ra_addr;
          rb_raddr = r0_rb_addr;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      ra_q     <= ra_raddr;
      rb_q     <= rb_raddr;
    end
  end

  // Gating with reset drops a transaction whose grant preceded the reset cycle.
  assign r0_rvalid  = !reset && (owner_q == OWN_R0);
  assign r1_rvalid  = !reset && (owner_q == OWN_R1);
  assign r0_ra_data = ra_rdata;
  assign r0_rb_data = rb_rdata;
  assign r1_rdata   = ra_rdata;

endmodule
